// File: rtl/sprite_move_scheduler.sv
// sprite_move_scheduler: owns the five sprite position registers and, once per
// game tick, walks the sprites through the external position update stage one at
// a time, writing each returned position back before moving to the next sprite.
module sprite_move_scheduler #(
  parameter int unsigned TICK_DIV       = 1666667,
  parameter int unsigned UPD_LATENCY    = 2,
  parameter logic [10:0] PACMAN_RESET_X = 11'd10,
  parameter logic [9:0]  PACMAN_RESET_Y = 10'd10,
  parameter logic [10:0] GHOST_RESET_X  = 11'd25,
  parameter logic [9:0]  GHOST_RESET_Y  = 10'd25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [19:0] dir_in,
  output logic [2:0]  upd_sprite,
  output logic [10:0] upd_pos_x,
  output logic [9:0]  upd_pos_y,
  output logic [3:0]  upd_dir,
  input  logic [10:0] upd_new_x,
  input  logic [9:0]  upd_new_y,
  output logic [54:0] pos_x_all,
  output logic [49:0] pos_y_all,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_overrun
);

  localparam int unsigned     NSPR        = 5;
  localparam int unsigned     TCW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCW-1:0]  TICK_LAST   = TCW'(TICK_DIV - 1);
  localparam logic [3:0]      WAIT_LOAD   = 4'(UPD_LATENCY - 1);
  localparam logic [2:0]      LAST_SPRITE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic           tick;
  logic [3:0]     wait_q, wait_d;
  logic [2:0]     idx_q, idx_d;
  logic [19:0]    snap_q, snap_d;
  logic           overrun_q, overrun_d;
  logic           capture;
  logic [3:0]     snap_nib;

  logic [10:0]    pos_x_q [NSPR];
  logic [9:0]     pos_y_q [NSPR];

  // Anything other than a single direction bit becomes "hold" for the stage.
  function automatic logic [3:0] onehot_or_hold(input logic [3:0] d);
    case (d)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return d;
      default:                            return 4'b0000;
    endcase
  endfunction

  function automatic logic [19:0] sanitize(input logic [19:0] raw);
    logic [19:0] s;
    s = '0;
    for (int unsigned i = 0; i < NSPR; i++) begin
      s[4*i +: 4] = onehot_or_hold(raw[4*i +: 4]);
    end
    return s;
  endfunction

  // Free-running tick divider; held at zero while the game is paused.
  always_comb begin
    tick       = enable && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_cnt_q + TCW'(1);
    if (!enable || tick) begin
      tick_cnt_d = '0;
    end
  end

  // Select the current sprite's position and snapshot direction nibble.
  always_comb begin
    upd_pos_x = '0;
    upd_pos_y = '0;
    snap_nib  = '0;
    for (int unsigned i = 0; i < NSPR; i++) begin
      if (idx_q == 3'(i)) begin
        upd_pos_x = pos_x_q[i];
        upd_pos_y = pos_y_q[i];
        snap_nib  = snap_q[4*i +: 4];
      end
    end
  end

  // Next-state logic and update-stage handshake outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    snap_d     = snap_q;
    capture    = 1'b0;
    overrun_d  = overrun_q | (tick && (state_q != S_IDLE));
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    upd_sprite = idx_q;
    upd_dir    = '0;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          snap_d  = sanitize(dir_in);
        end
      end
      S_ISSUE: begin
        upd_dir = snap_nib;
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        upd_dir = snap_nib;
        if (wait_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        upd_dir = snap_nib;
        capture = 1'b1;
        if (idx_q == LAST_SPRITE) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state registers; reset overrides ticks and any transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      wait_q     <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      wait_q     <= wait_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      overrun_q  <= overrun_d;
    end
  end

  // Position registers: write back the stage result for the current sprite.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q[0] <= PACMAN_RESET_X;
      pos_y_q[0] <= PACMAN_RESET_Y;
      for (int unsigned i = 1; i < NSPR; i++) begin
        pos_x_q[i] <= GHOST_RESET_X;
        pos_y_q[i] <= GHOST_RESET_Y;
      end
    end else if (capture) begin
      for (int unsigned i = 0; i < NSPR; i++) begin
        if (idx_q == 3'(i)) begin
          pos_x_q[i] <= upd_new_x;
          pos_y_q[i] <= upd_new_y;
        end
      end
    end
  end

  // Pack positions for the renderer and collision logic.
  always_comb begin
    pos_x_all = '0;
    pos_y_all = '0;
    for (int unsigned i = 0; i < NSPR; i++) begin
      pos_x_all[11*i +: 11] = pos_x_q[i];
      pos_y_all[10*i +: 10] = pos_y_q[i];
    end
  end

  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Testbench for sprite_move_scheduler: scoreboard of expected per-frame results,
// with a monitor that checks the sprite walk and write-back on each frame.
module tb_sprite_move_scheduler;

  localparam logic [3:0] DR = 4'b0001;
  localparam logic [3:0] DU = 4'b0010;
  localparam logic [3:0] DD = 4'b0100;
  localparam logic [3:0] DL = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic        enable_b;
  logic [19:0] dir_in;
  logic [19:0] dir_b;

  logic [2:0]  upd_sprite, upd_sprite_b;
  logic [10:0] upd_pos_x, upd_pos_x_b, upd_new_x, upd_new_x_b;
  logic [9:0]  upd_pos_y, upd_pos_y_b, upd_new_y, upd_new_y_b;
  logic [3:0]  upd_dir, upd_dir_b;
  logic [54:0] pos_x_all, pos_x_all_b;
  logic [49:0] pos_y_all, pos_y_all_b;
  logic        busy, busy_b, frame_done, frame_done_b, frame_overrun, frame_overrun_b;

  sprite_move_scheduler #(.TICK_DIV(32), .UPD_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dir_in(dir_in),
    .upd_sprite(upd_sprite), .upd_pos_x(upd_pos_x), .upd_pos_y(upd_pos_y),
    .upd_dir(upd_dir), .upd_new_x(upd_new_x), .upd_new_y(upd_new_y),
    .pos_x_all(pos_x_all), .pos_y_all(pos_y_all), .busy(busy),
    .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  sprite_move_scheduler #(.TICK_DIV(10), .UPD_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .dir_in(dir_b),
    .upd_sprite(upd_sprite_b), .upd_pos_x(upd_pos_x_b), .upd_pos_y(upd_pos_y_b),
    .upd_dir(upd_dir_b), .upd_new_x(upd_new_x_b), .upd_new_y(upd_new_y_b),
    .pos_x_all(pos_x_all_b), .pos_y_all(pos_y_all_b), .busy(busy_b),
    .frame_done(frame_done_b), .frame_overrun(frame_overrun_b)
  );

  // Position update stage model: 2-cycle registered, +/-15 per direction.
  function automatic logic [20:0] stage_f(input logic [10:0] x, input logic [9:0] y,
                                          input logic [3:0] d);
    logic [10:0] nx;
    logic [9:0]  ny;
    nx = x;
    ny = y;
    case (d)
      4'b0001: nx = x + 11'd15;
      4'b1000: nx = x - 11'd15;
      4'b0010: ny = y + 10'd15;
      4'b0100: ny = y - 10'd15;
      default: ;
    endcase
    return {nx, ny};
  endfunction

  logic [20:0] st1_a, st2_a, st1_b, st2_b;
  always @(posedge clk) begin
    st1_a <= stage_f(upd_pos_x, upd_pos_y, upd_dir);
    st2_a <= st1_a;
    st1_b <= stage_f(upd_pos_x_b, upd_pos_y_b, upd_dir_b);
    st2_b <= st1_b;
  end
  assign upd_new_x   = st2_a[20:10];
  assign upd_new_y   = st2_a[9:0];
  assign upd_new_x_b = st2_b[20:10];
  assign upd_new_y_b = st2_b[9:0];

  typedef struct {
    logic [54:0] x;
    logic [49:0] y;
    logic [19:0] dir;
    bit          abort;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [54:0] x, input logic [49:0] y,
                          input logic [19:0] dir, input bit ab);
    exp_t e;
    e.x     = x;
    e.y     = y;
    e.dir   = dir;
    e.abort = ab;
    exp_q.push_back(e);
  endtask

  // Monitor: checks the sprite walk every frame cycle and positions at DONE.
  exp_t cur;
  int   cyc;
  int   exp_spr;
  bit   in_frame = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_frame) begin
          check("abort_record_present", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("frame_expected_abort", 64'(cur.abort), 1);
          end
        end
        in_frame = 1'b0;
      end else begin
        if (!in_frame && busy) begin
          in_frame = 1'b1;
          cyc      = 0;
          check("frame_expected", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) cur = exp_q[0];
          else cur = '{default: '0};
        end else if (!in_frame && frame_done) begin
          check("stray_frame_done", 64'(frame_done), 0);
        end
        if (in_frame) begin
          if (cyc < 20) begin
            exp_spr = cyc / 4;
            check("upd_sprite", 64'(upd_sprite), 64'(exp_spr));
            check("upd_dir", 64'(upd_dir), 64'(cur.dir[4*exp_spr +: 4]));
            check("busy_in_frame", 64'(busy), 1);
            check("early_frame_done", 64'(frame_done), 0);
          end else begin
            check("frame_done_21_after_tick", 64'(frame_done), 1);
            check("upd_dir_in_done", 64'(upd_dir), 0);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              check("frame_not_abort", 64'(cur.abort), 0);
              check("pos_x_all", 64'(pos_x_all), 64'(cur.x));
              check("pos_y_all", 64'(pos_y_all), 64'(cur.y));
            end
            in_frame = 1'b0;
          end
          cyc++;
        end
      end
    end
  end

  task automatic wait_busy(input int max_cycles);
    int n = 0;
    while (n < max_cycles && !busy) begin
      @(negedge clk);
      n++;
    end
    check("busy_seen", 64'(busy), 1);
  endtask

  task automatic wait_done_and_stop(input int max_cycles);
    int n = 0;
    while (n < max_cycles && !frame_done) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", 64'(frame_done), 1);
    @(posedge clk);
    #1 enable = 1'b0;
  endtask

  localparam logic [54:0] X_RST = {11'd25, 11'd25, 11'd25, 11'd25, 11'd10};
  localparam logic [49:0] Y_RST = {10'd25, 10'd25, 10'd25, 10'd25, 10'd10};

  int n_done;
  int done_at;

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    enable_b = 1'b0;
    dir_in   = '0;
    dir_b    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_pos_x", 64'(pos_x_all), 64'(X_RST));
    check("rst_pos_y", 64'(pos_y_all), 64'(Y_RST));
    check("rst_busy", 64'(busy), 0);
    check("rst_frame_done", 64'(frame_done), 0);
    check("rst_upd_dir", 64'(upd_dir), 0);
    check("rst_upd_sprite", 64'(upd_sprite), 0);
    check("rst_overrun", 64'(frame_overrun), 0);

    // Single frame: Pacman moves right
    dir_in = {4'b0, 4'b0, 4'b0, 4'b0, DR};
    push_exp({11'd25, 11'd25, 11'd25, 11'd25, 11'd25}, Y_RST, 20'h00001, 1'b0);
    enable = 1'b1;
    wait_done_and_stop(100);

    // Invalid nibble for sprite 2, sprite 3 up
    @(posedge clk);
    #1 dir_in = {4'b0, DU, 4'b0011, 4'b0, 4'b0};
    push_exp({11'd25, 11'd25, 11'd25, 11'd25, 11'd25},
             {10'd25, 10'd40, 10'd25, 10'd25, 10'd10}, 20'h02000, 1'b0);
    enable = 1'b1;
    wait_done_and_stop(100);

    // Sprite 4 DOWN, changed to LEFT during sprite 1's wait
    @(posedge clk);
    #1 dir_in = {DD, 4'b0, 4'b0, 4'b0, 4'b0};
    push_exp({11'd25, 11'd25, 11'd25, 11'd25, 11'd25},
             {10'd10, 10'd40, 10'd25, 10'd25, 10'd10}, 20'h40000, 1'b0);
    enable = 1'b1;
    wait_busy(100);
    repeat (5) @(posedge clk);
    #1 dir_in = {DL, 4'b0, 4'b0, 4'b0, 4'b0};
    wait_done_and_stop(60);
    push_exp({11'd10, 11'd25, 11'd25, 11'd25, 11'd25},
             {10'd10, 10'd40, 10'd25, 10'd25, 10'd10}, 20'h80000, 1'b0);
    enable = 1'b1;
    wait_done_and_stop(100);

    // Reset during sprite 3's wait
    @(posedge clk);
    #1 dir_in = {DR, DD, DL, DR, DU};
    push_exp('0, '0, 20'h14812, 1'b1);
    enable = 1'b1;
    wait_busy(100);
    repeat (13) @(posedge clk);
    #1;
    check("mid_s0_y", 64'(pos_y_all[9:0]), 25);
    check("mid_s1_x", 64'(pos_x_all[21:11]), 40);
    check("mid_s2_x", 64'(pos_x_all[32:22]), 10);
    check("mid_s3_y_untouched", 64'(pos_y_all[39:30]), 40);
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_pos_x", 64'(pos_x_all), 64'(X_RST));
    check("abort_pos_y", 64'(pos_y_all), 64'(Y_RST));
    check("abort_busy", 64'(busy), 0);
    check("abort_upd_sprite", 64'(upd_sprite), 0);
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_done) n_done++;
    end
    check("abort_no_frame_done", 64'(n_done), 0);

    // Next tick restarts from sprite 0
    push_exp({11'd40, 11'd25, 11'd10, 11'd40, 11'd10},
             {10'd25, 10'd10, 10'd25, 10'd25, 10'd25}, 20'h14812, 1'b0);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_done_and_stop(100);

    // Overrun on the fast-tick instance
    @(posedge clk);
    #1 enable_b = 1'b1;
    begin
      int n = 0;
      while (n < 50 && !busy_b) begin
        @(negedge clk);
        n++;
      end
    end
    check("b_busy_seen", 64'(busy_b), 1);
    check("b_overrun_first_tick", 64'(frame_overrun_b), 0);
    done_at = -1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 9)  check("b_overrun_before_2nd", 64'(frame_overrun_b), 0);
      if (i == 10) check("b_overrun_after_2nd", 64'(frame_overrun_b), 1);
      if (i <= 20) check("b_busy_continuous", 64'(busy_b), 1);
      if (frame_done_b && done_at < 0) done_at = i;
    end
    check("b_frame_length", 64'(done_at), 20);
    repeat (40) @(negedge clk);
    check("b_overrun_sticky", 64'(frame_overrun_b), 1);
    enable_b = 1'b0;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
